// File: rtl/progmem_arbiter_pkg.sv
// progmem_arbiter_pkg: shared widths and the fetch tag type
`ifndef INST_W
`define INST_W 32
`endif
`ifndef INST_ADDR_W
`define INST_ADDR_W 16
`endif
`ifndef PMARB_ID_W
`define PMARB_ID_W 3
`endif

package progmem_arbiter_pkg;

    localparam int ID_W = `PMARB_ID_W;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/progmem_arbiter_if.sv
// progmem_arbiter_if: per-core fetch bus plus the shared program-memory port
interface progmem_arbiter_if #(
    parameter int N_CORES     = 4,
    parameter int INST_W      = `INST_W,
    parameter int INST_ADDR_W = `INST_ADDR_W
);

    logic [N_CORES-1:0]             core_req;
    logic [N_CORES*INST_ADDR_W-1:0] core_addr;
    logic [N_CORES-1:0]             core_gnt;
    logic [N_CORES-1:0]             core_rvalid;
    logic [INST_W-1:0]              core_rdata;
    logic                           mem_en;
    logic [INST_ADDR_W-1:0]         mem_addr;
    logic [INST_W-1:0]              mem_rdata;

    modport slave (
        input  core_req, core_addr, mem_rdata,
        output core_gnt, core_rvalid, core_rdata, mem_en, mem_addr
    );

    modport master (
        output core_req, core_addr, mem_rdata,
        input  core_gnt, core_rvalid, core_rdata, mem_en, mem_addr
    );

endinterface

// File: rtl/progmem_arbiter_rr_picker.sv
// progmem_arbiter_rr_picker: combinational round-robin priority encoder starting at ptr
module progmem_arbiter_rr_picker
    import progmem_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     eligible,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [ID_W-1:0]  idx,
    output logic             any
);

    int best;
    int rank;

    // rank each core by its distance from ptr (mod N); the eligible core with the lowest rank wins
    always_comb begin
        best = N;
        rank = 0;
        idx  = '0;
        for (int i = 0; i < N; i++) begin
            rank = (i >= int'(ptr)) ? i - int'(ptr) : i + N - int'(ptr);
            if (eligible[i] && rank < best) begin
                best = rank;
                idx  = ID_W'(i);
            end
        end
    end

    assign any = best < N;
    assign gnt = any ? (N'(1) << idx) : '0;

endmodule

// File: rtl/progmem_arbiter.sv
// progmem_arbiter: round-robin sharing of one program-memory read port among fetch cores
module progmem_arbiter
    import progmem_arbiter_pkg::*;
#(
    parameter int N_CORES     = 4,
    parameter int INST_W      = `INST_W,
    parameter int INST_ADDR_W = `INST_ADDR_W,
    parameter int MEM_LAT     = 1
) (
    input logic               clk,
    input logic               rst_n,
    input logic               en,
    progmem_arbiter_if.slave  bus
);

    localparam int PTR_W = $clog2(N_CORES);

    logic [N_CORES-1:0]     pending;
    logic [N_CORES-1:0]     eligible;
    logic [N_CORES-1:0]     gnt;
    logic [N_CORES-1:0]     rvalid;
    logic [PTR_W-1:0]       rr_ptr;
    logic [ID_W-1:0]        gnt_idx;
    logic                   gnt_any;
    logic [INST_ADDR_W-1:0] mem_addr;
    tag_t                   tags [MEM_LAT];

    // reset also masks eligibility so no grant is visible while rst_n is low
    assign eligible = bus.core_req & ~pending & {N_CORES{en & rst_n}};

    progmem_arbiter_rr_picker #(.N(N_CORES), .PTR_W(PTR_W)) u_rr_picker (
        .eligible (eligible),
        .ptr      (rr_ptr),
        .gnt      (gnt),
        .idx      (gnt_idx),
        .any      (gnt_any)
    );

    // route the granted core's address to memory, zero when idle
    always_comb begin
        mem_addr = '0;
        for (int i = 0; i < N_CORES; i++)
            if (gnt[i]) mem_addr = bus.core_addr[i*INST_ADDR_W +: INST_ADDR_W];
    end

    assign rvalid          = tags[MEM_LAT-1].valid ? (N_CORES'(1) << tags[MEM_LAT-1].id) : '0;
    assign bus.core_gnt    = gnt;
    assign bus.core_rvalid = rvalid;
    assign bus.core_rdata  = INST_W'(bus.mem_rdata);
    assign bus.mem_en      = gnt_any;
    assign bus.mem_addr    = mem_addr;

    // track outstanding fetches, advance the pointer past each winner, shift tags every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            rr_ptr  <= '0;
            for (int s = 0; s < MEM_LAT; s++) tags[s] <= '0;
        end else begin
            pending <= (pending & ~rvalid) | gnt;
            if (gnt_any) rr_ptr <= (gnt_idx == ID_W'(N_CORES - 1)) ? '0 : PTR_W'(gnt_idx + 1'b1);
            tags[0] <= '{valid: gnt_any, id: gnt_idx};
            for (int s = 1; s < MEM_LAT; s++) tags[s] <= tags[s-1];
        end
    end

endmodule

// File: tb/tb_progmem_arbiter.sv
// tb_progmem_arbiter: directed checks of grants, returns, enable and reset on three memory latencies
module tb_progmem_arbiter;

    localparam int N  = 4;
    localparam int IW = 32;
    localparam int AW = 16;

    logic clk = 1'b0;
    logic rst1, rst2, rst3;
    logic en1, en2, en3;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    progmem_arbiter_if #(.N_CORES(N), .INST_W(IW), .INST_ADDR_W(AW)) b1 ();
    progmem_arbiter_if #(.N_CORES(N), .INST_W(IW), .INST_ADDR_W(AW)) b2 ();
    progmem_arbiter_if #(.N_CORES(N), .INST_W(IW), .INST_ADDR_W(AW)) b3 ();

    progmem_arbiter #(.N_CORES(N), .INST_W(IW), .INST_ADDR_W(AW), .MEM_LAT(1)) u1 (
        .clk(clk), .rst_n(rst1), .en(en1), .bus(b1.slave));
    progmem_arbiter #(.N_CORES(N), .INST_W(IW), .INST_ADDR_W(AW), .MEM_LAT(2)) u2 (
        .clk(clk), .rst_n(rst2), .en(en2), .bus(b2.slave));
    progmem_arbiter #(.N_CORES(N), .INST_W(IW), .INST_ADDR_W(AW), .MEM_LAT(3)) u3 (
        .clk(clk), .rst_n(rst3), .en(en3), .bus(b3.slave));

    // memory content at address a is {~a, a}; read pipelines of depth 1, 2, 3
    logic [IW-1:0]      m1;
    logic [1:0][IW-1:0] m2;
    logic [2:0][IW-1:0] m3;

    always @(posedge clk) begin
        m1 <= {~b1.mem_addr, b1.mem_addr};
        m2 <= {m2[0], {~b2.mem_addr, b2.mem_addr}};
        m3 <= {m3[1:0], {~b3.mem_addr, b3.mem_addr}};
    end

    assign b1.mem_rdata = m1;
    assign b2.mem_rdata = m2[1];
    assign b3.mem_rdata = m3[2];

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        rst1 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
        en1 = 1'b1; en2 = 1'b1; en3 = 1'b1;
        b1.core_req = '0; b1.core_addr = '0;
        b2.core_req = '0; b2.core_addr = '0;
        b3.core_req = '0; b3.core_addr = '0;
        b1.core_req = 4'b1111;
        mid();
        check("rst_gnt", b1.core_gnt, 0);
        check("rst_rvalid", b1.core_rvalid, 0);
        check("rst_mem_en", b1.mem_en, 0);
        check("rst_mem_addr", b1.mem_addr, 0);
        tick();
        rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
        b1.core_req = '0;

        // single request from core 2
        b1.core_addr[2*AW +: AW] = 16'h0010;
        b1.core_req = 4'b0100;
        mid();
        check("t1_gnt", b1.core_gnt, 4'b0100);
        check("t1_mem_en", b1.mem_en, 1);
        check("t1_mem_addr", b1.mem_addr, 16'h0010);
        tick();
        b1.core_req = '0;
        mid();
        check("t1_rvalid", b1.core_rvalid, 4'b0100);
        check("t1_rdata", b1.core_rdata, 32'hffef_0010);
        check("t1_rr_ptr", u1.rr_ptr, 3);
        check("t1_gnt_after", b1.core_gnt, 0);
        tick();
        mid();
        check("t1_rvalid_once", b1.core_rvalid, 0);

        // all four cores request continuously from a fresh pointer
        tick();
        rst1 = 1'b0;
        tick();
        rst1 = 1'b1;
        for (int i = 0; i < N; i++) b1.core_addr[i*AW +: AW] = 16'h0100 + 16'(i);
        b1.core_req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            mid();
            check($sformatf("rr_gnt%0d", k), b1.core_gnt, 4'b1 << (k % 4));
            check($sformatf("rr_addr%0d", k), b1.mem_addr, 16'h0100 + k % 4);
            check($sformatf("rr_rvalid%0d", k), b1.core_rvalid, k == 0 ? 0 : 4'b1 << ((k - 1) % 4));
            tick();
        end
        b1.core_req = '0;
        mid();
        check("rr_last_rvalid", b1.core_rvalid, 4'b1000);
        check("rr_last_rdata", b1.core_rdata, 32'hfefc_0103);
        check("rr_idle_gnt", b1.core_gnt, 0);
        tick();

        // core 1 loses to core 0, then withdraws its request
        b1.core_req = 4'b0011;
        mid();
        check("drop_gnt0", b1.core_gnt, 4'b0001);
        check("drop_addr0", b1.mem_addr, 16'h0100);
        tick();
        b1.core_req = '0;
        mid();
        check("drop_gnt", b1.core_gnt, 0);
        check("drop_mem_en", b1.mem_en, 0);
        check("drop_mem_addr", b1.mem_addr, 0);
        check("drop_rvalid", b1.core_rvalid, 4'b0001);
        tick();
        b1.core_req = 4'b0100;
        mid();
        check("drop_gnt2", b1.core_gnt, 4'b0100);
        check("drop_addr2", b1.mem_addr, 16'h0102);
        tick();
        b1.core_req = '0;
        mid();
        check("drop_rvalid2", b1.core_rvalid, 4'b0100);
        tick();

        // latency 3: core 0 alone, one grant every four cycles
        b3.core_addr[0*AW +: AW] = 16'h0030;
        b3.core_addr[1*AW +: AW] = 16'h0031;
        b3.core_addr[3*AW +: AW] = 16'h0033;
        b3.core_req = 4'b0001;
        for (int k = 0; k < 9; k++) begin
            mid();
            check($sformatf("lat3_gnt%0d", k), b3.core_gnt, (k % 4 == 0) ? 1 : 0);
            check($sformatf("lat3_mem_en%0d", k), b3.mem_en, (k % 4 == 0) ? 1 : 0);
            check($sformatf("lat3_rvalid%0d", k), b3.core_rvalid, (k % 4 == 3) ? 1 : 0);
            if (k % 4 == 3) check($sformatf("lat3_rdata%0d", k), b3.core_rdata, 32'hffcf_0030);
            tick();
        end

        // enable low for five cycles with one read in flight
        b3.core_req = 4'b1010;
        en3 = 1'b0;
        for (int k = 9; k < 14; k++) begin
            mid();
            check($sformatf("en_gnt%0d", k), b3.core_gnt, 0);
            check($sformatf("en_mem_en%0d", k), b3.mem_en, 0);
            check($sformatf("en_rvalid%0d", k), b3.core_rvalid, (k == 11) ? 1 : 0);
            tick();
        end
        en3 = 1'b1;
        mid();
        check("en_back_gnt", b3.core_gnt, 4'b0010);
        check("en_back_addr", b3.mem_addr, 16'h0031);
        #1 en3 = 1'b0;
        #1;
        check("en_drop_gnt", b3.core_gnt, 0);
        check("en_drop_mem_en", b3.mem_en, 0);
        en3 = 1'b1;
        #1;
        check("en_restore_gnt", b3.core_gnt, 4'b0010);
        tick();
        mid();
        check("en_next_gnt", b3.core_gnt, 4'b1000);
        check("en_next_addr", b3.mem_addr, 16'h0033);
        tick();
        b3.core_req = '0;
        mid();
        check("en_wait_rvalid", b3.core_rvalid, 0);
        tick();
        mid();
        check("en_rvalid1", b3.core_rvalid, 4'b0010);
        check("en_rdata1", b3.core_rdata, 32'hffce_0031);
        tick();
        mid();
        check("en_rvalid3", b3.core_rvalid, 4'b1000);
        check("en_rdata3", b3.core_rdata, 32'hffcc_0033);
        tick();

        // latency 2: reset with two reads in flight
        b2.core_addr[1*AW +: AW] = 16'h0041;
        b2.core_addr[2*AW +: AW] = 16'h0042;
        b2.core_addr[3*AW +: AW] = 16'h0043;
        b2.core_req = 4'b0110;
        mid();
        check("mr_gnt1", b2.core_gnt, 4'b0010);
        tick();
        mid();
        check("mr_gnt2", b2.core_gnt, 4'b0100);
        tick();
        rst2 = 1'b0;
        #1;
        check("mr_rst_gnt", b2.core_gnt, 0);
        check("mr_rst_rvalid", b2.core_rvalid, 0);
        check("mr_rst_mem_en", b2.mem_en, 0);
        check("mr_rst_mem_addr", b2.mem_addr, 0);
        b2.core_req = 4'b1100;
        mid();
        check("mr_rst_rvalid_mid", b2.core_rvalid, 0);
        tick();
        rst2 = 1'b1;
        mid();
        check("mr_first_gnt", b2.core_gnt, 4'b0100);
        check("mr_first_addr", b2.mem_addr, 16'h0042);
        check("mr_no_rvalid0", b2.core_rvalid, 0);
        tick();
        mid();
        check("mr_second_gnt", b2.core_gnt, 4'b1000);
        check("mr_no_rvalid1", b2.core_rvalid, 0);
        tick();
        b2.core_req = '0;
        mid();
        check("mr_rvalid2", b2.core_rvalid, 4'b0100);
        check("mr_rdata2", b2.core_rdata, 32'hffbd_0042);
        tick();
        mid();
        check("mr_rvalid3", b2.core_rvalid, 4'b1000);
        check("mr_rdata3", b2.core_rdata, 32'hffbc_0043);
        tick();
        mid();
        check("mr_rvalid_end", b2.core_rvalid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
